// File: rtl/proc_core_hs.sv
// Multicycle 16-bit-instruction processor core: FSM controller, 16-entry register file,
// ALU and PC, with ready/valid handshakes to external instruction and data memories.
module proc_core_hs #(
    parameter int WIDTH    = 16,
    parameter int I_ADDR_W = 7,
    parameter int D_ADDR_W = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    output logic                I_req,
    output logic [I_ADDR_W-1:0] I_addr,
    input  logic                I_valid,
    input  logic [15:0]         I_data,
    output logic                D_req,
    output logic                D_we,
    output logic [D_ADDR_W-1:0] D_addr,
    output logic [WIDTH-1:0]    D_wdata,
    input  logic                D_ready,
    input  logic [WIDTH-1:0]    D_rdata,
    output logic                Halted,
    output logic [15:0]         IR_Out,
    output logic [I_ADDR_W-1:0] PC_Out,
    output logic [3:0]          State,
    output logic [3:0]          NextState,
    output logic [WIDTH-1:0]    ALU_A,
    output logic [WIDTH-1:0]    ALU_B,
    output logic [WIDTH-1:0]    ALU_Out
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_HALT   = 4'd6
    } state_t;

    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_LDI   = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_JZ    = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t                state_q, state_d;
    logic [I_ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]           ir_q, ir_d;
    logic [WIDTH-1:0]      a_q, a_d;
    logic [WIDTH-1:0]      b_q, b_d;
    logic [WIDTH-1:0]      mdr_q, mdr_d;
    logic [WIDTH-1:0]      rf_q [16];
    logic                  rf_we;
    logic [WIDTH-1:0]      wb_data;
    logic [3:0]            op;
    logic                  in_mem;
    logic                  is_store;

    function automatic logic [WIDTH-1:0] sext_imm(input logic signed [7:0] imm);
        logic signed [WIDTH-1:0] ext;
        ext = WIDTH'(imm);
        return ext;
    endfunction

    assign op       = ir_q[15:12];
    assign in_mem   = (state_q == S_MEM);
    assign is_store = (op == OP_STORE);

    always_comb begin
        ALU_Out = '0;
        case (op)
            OP_ADD:  ALU_Out = a_q + b_q;
            OP_SUB:  ALU_Out = a_q - b_q;
            OP_AND:  ALU_Out = a_q & b_q;
            OP_OR:   ALU_Out = a_q | b_q;
            OP_XOR:  ALU_Out = a_q ^ b_q;
            OP_LDI:  ALU_Out = b_q;
            default: ALU_Out = '0;
        endcase
    end

    assign wb_data = (op == OP_LOAD) ? mdr_q : ALU_Out;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        mdr_d   = mdr_q;
        rf_we   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (I_valid) begin
                    ir_d    = I_data;
                    pc_d    = pc_q + I_ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = rf_q[ir_q[11:8]];
                b_d = (op == OP_LDI) ? sext_imm(ir_q[11:4]) : rf_q[ir_q[7:4]];
                case (op)
                    OP_STORE, OP_LOAD: state_d = S_MEM;
                    OP_HALT:           state_d = S_HALT;
                    default:           state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI: state_d = S_WB;
                    // A taken jump replaces the increment done during fetch
                    OP_JMP: pc_d = ir_q[I_ADDR_W-1:0];
                    OP_JZ:  if (a_q == '0) pc_d = ir_q[I_ADDR_W-1:0];
                    default: ;
                endcase
            end
            S_MEM: begin
                if (D_ready) begin
                    if (is_store) begin
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = D_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mdr_q   <= '0;
            for (int i = 0; i < 16; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mdr_q   <= mdr_d;
            if (rf_we) rf_q[ir_q[3:0]] <= wb_data;
        end
    end

    // Reset gates the fetch request so it is low while Reset is held
    assign I_req     = (state_q == S_FETCH) && Reset;
    assign I_addr    = pc_q;
    assign D_req     = in_mem;
    assign D_we      = in_mem && is_store;
    assign D_addr    = !in_mem ? '0 : (is_store ? ir_q[D_ADDR_W-1:0] : ir_q[4 +: D_ADDR_W]);
    assign D_wdata   = (in_mem && is_store) ? a_q : '0;
    assign Halted    = (state_q == S_HALT);
    assign IR_Out    = ir_q;
    assign PC_Out    = pc_q;
    assign State     = state_q;
    assign NextState = state_d;
    assign ALU_A     = a_q;
    assign ALU_B     = b_q;

endmodule

// File: tb/tb_proc_core_hs.sv
// Directed bench for proc_core_hs: 16-bit core with instruction/data memory models,
// plus an 8-bit instance running a fixed SUB-wrap program.
module tb_proc_core_hs;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    logic        I_req, I_valid, D_req, D_we, D_ready, Halted;
    logic [6:0]  I_addr, PC_Out;
    logic [15:0] I_data, IR_Out, D_wdata, D_rdata, ALU_A, ALU_B, ALU_Out;
    logic [7:0]  D_addr;
    logic [3:0]  State, NextState;

    logic        I_req8, I_valid8, D_req8, D_we8, D_ready8, Halted8;
    logic [6:0]  I_addr8, PC_Out8;
    logic [15:0] I_data8, IR_Out8;
    logic [7:0]  D_addr8, D_wdata8, D_rdata8, ALU_A8, ALU_B8, ALU_Out8;
    logic [3:0]  State8, NextState8;

    logic [15:0] imem  [0:127];
    logic [15:0] imem8 [0:127];
    logic [15:0] dmem  [0:255];

    int          d_wait = 0;
    int          dcnt = 0;
    int          wr_cnt = 0;
    int          dreq_cyc = 0;
    int          unstable = 0;
    logic [7:0]  a0 = '0;
    logic [15:0] w0 = '0;
    logic [7:0]  s8_data = '0;
    int          s8_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    proc_core_hs #(.WIDTH(16), .I_ADDR_W(7), .D_ADDR_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .I_req(I_req), .I_addr(I_addr), .I_valid(I_valid),
        .I_data(I_data), .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_wdata(D_wdata),
        .D_ready(D_ready), .D_rdata(D_rdata), .Halted(Halted), .IR_Out(IR_Out),
        .PC_Out(PC_Out), .State(State), .NextState(NextState), .ALU_A(ALU_A),
        .ALU_B(ALU_B), .ALU_Out(ALU_Out)
    );

    proc_core_hs #(.WIDTH(8), .I_ADDR_W(7), .D_ADDR_W(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .I_req(I_req8), .I_addr(I_addr8), .I_valid(I_valid8),
        .I_data(I_data8), .D_req(D_req8), .D_we(D_we8), .D_addr(D_addr8), .D_wdata(D_wdata8),
        .D_ready(D_ready8), .D_rdata(D_rdata8), .Halted(Halted8), .IR_Out(IR_Out8),
        .PC_Out(PC_Out8), .State(State8), .NextState(NextState8), .ALU_A(ALU_A8),
        .ALU_B(ALU_B8), .ALU_Out(ALU_Out8)
    );

    assign I_valid  = I_req;
    assign I_data   = imem[I_addr];
    assign D_ready  = D_req && (dcnt >= d_wait);
    assign D_rdata  = dmem[D_addr];
    assign I_valid8 = I_req8;
    assign I_data8  = imem8[I_addr8];
    assign D_ready8 = D_req8;
    assign D_rdata8 = 8'h00;

    always @(posedge Clk) begin
        if (!D_req || D_ready) dcnt <= 0;
        else dcnt <= dcnt + 1;
        if (D_req && D_ready && D_we) begin
            dmem[D_addr] = D_wdata;
            wr_cnt = wr_cnt + 1;
        end
        if (D_req8 && D_we8) begin
            s8_data = D_wdata8;
            s8_cnt = s8_cnt + 1;
        end
    end

    always @(negedge Clk) begin
        if (D_req) begin
            if (dreq_cyc == 0) begin
                a0 = D_addr;
                w0 = D_wdata;
            end else if (D_addr !== a0 || D_wdata !== w0) begin
                unstable = unstable + 1;
            end
            dreq_cyc = dreq_cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 128; i++) imem[i] = 16'hF000;
    endtask

    task automatic start_reset();
        Reset = 1'b0;
        #1;
        clear_imem();
        wr_cnt = 0;
        dreq_cyc = 0;
        unstable = 0;
        d_wait = 0;
    endtask

    task automatic release_reset();
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic run_to_halt(input int start, input int maxc, output int cyc);
        cyc = start;
        while (!Halted && cyc < maxc) begin
            step(1);
            cyc++;
        end
        chk("halt_reached", Halted, 1'b1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
        int          cyc;
    } vec_t;
    vec_t vt [8];

    initial begin
        int cyc;
        vt[0] = '{4'h3, 8'h05, 8'hFD, 16'h0002, 17};
        vt[1] = '{4'h4, 8'h00, 8'h01, 16'hFFFF, 17};
        vt[2] = '{4'h5, 8'h5A, 8'h0F, 16'h000A, 17};
        vt[3] = '{4'h6, 8'h50, 8'h0F, 16'h005F, 17};
        vt[4] = '{4'h7, 8'hFF, 8'h0F, 16'hFFF0, 17};
        vt[5] = '{4'h3, 8'h80, 8'h80, 16'hFF00, 17};
        vt[6] = '{4'h4, 8'h7F, 8'h80, 16'h00FF, 17};
        vt[7] = '{4'hC, 8'h05, 8'h03, 16'h0000, 16};

        for (int i = 0; i < 128; i++) imem8[i] = 16'hF000;
        imem8[0] = 16'h8001;
        imem8[1] = 16'h8012;
        imem8[2] = 16'h4123;
        imem8[3] = 16'h1310;
        for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;

        // Reset state and the LDI/LDI/ADD/HALT program
        start_reset();
        imem[0] = 16'h8051;
        imem[1] = 16'h8FD2;
        imem[2] = 16'h3123;
        step(1);
        chk("rst_state", State, 4'd1);
        chk("rst_pc", PC_Out, 7'd0);
        chk("rst_ir", IR_Out, 16'h0000);
        chk("rst_ireq", I_req, 1'b0);
        chk("rst_dreq", D_req, 1'b0);
        chk("rst_dwe", D_we, 1'b0);
        chk("rst_halted", Halted, 1'b0);
        chk("rst_alu_a", ALU_A, 16'h0000);
        chk("rst_alu_b", ALU_B, 16'h0000);
        chk("rst_daddr", D_addr, 8'h00);
        chk("rst_dwdata", D_wdata, 16'h0000);
        release_reset();
        #1;
        chk("fetch_ireq", I_req, 1'b1);
        step(2);
        chk("ldi_state_exec", State, 4'd3);
        chk("ldi_next_wb", NextState, 4'd5);
        chk("ldi_alu_out", ALU_Out, 16'h0005);
        step(8);
        chk("add_alu_a", ALU_A, 16'h0005);
        chk("add_alu_b", ALU_B, 16'hFFFD);
        chk("add_alu_out", ALU_Out, 16'h0002);
        run_to_halt(10, 40, cyc);
        chk("halt_cycle", cyc + 1, 15);
        chk("halt_pc", PC_Out, 7'd4);
        step(4);
        chk("halt_absorb_state", State, 4'd6);
        chk("halt_absorb_ireq", I_req, 1'b0);
        chk("halt_absorb_pc", PC_Out, 7'd4);

        // ALU table: LDI R1,a; LDI R2,b; op R1,R2->R3; STORE R3->0x10; HALT
        for (int v = 0; v < 8; v++) begin
            start_reset();
            imem[0] = {4'h8, vt[v].a, 4'h1};
            imem[1] = {4'h8, vt[v].b, 4'h2};
            imem[2] = {vt[v].op, 4'h1, 4'h2, 4'h3};
            imem[3] = 16'h1310;
            dmem[16] = 16'hAAAA;
            release_reset();
            run_to_halt(0, 60, cyc);
            chk($sformatf("vec%0d_result", v), dmem[16], vt[v].exp);
            chk($sformatf("vec%0d_cycles", v), cyc, vt[v].cyc);
            chk($sformatf("vec%0d_writes", v), wr_cnt, 1);
            if (v == 0) begin
                chk("w8_sub_wrap", s8_data, 8'hFF);
                chk("w8_halted", Halted8, 1'b1);
            end
        end

        // STORE with D_ready delayed 3 cycles
        start_reset();
        imem[0] = 16'h8343;
        imem[1] = 16'h1320;
        d_wait = 3;
        release_reset();
        run_to_halt(0, 60, cyc);
        chk("st_cycles", cyc, 12);
        chk("st_dreq_cycles", dreq_cyc, 4);
        chk("st_unstable", unstable, 0);
        chk("st_addr", a0, 8'h20);
        chk("st_wdata", w0, 16'h0034);
        chk("st_writes", wr_cnt, 1);
        chk("st_mem", dmem[32], 16'h0034);

        // LOAD 0x20 -> R4, then STORE R4 -> 0x30
        start_reset();
        dmem[32] = 16'h1234;
        dmem[48] = 16'h0000;
        imem[0] = 16'h2204;
        imem[1] = 16'h1430;
        d_wait = 1;
        release_reset();
        run_to_halt(0, 60, cyc);
        chk("ld_cycles", cyc, 11);
        chk("ld_value", dmem[48], 16'h1234);

        // JMP taken, JZ not taken on a nonzero register
        start_reset();
        imem[0]  = 16'h9010;
        imem[16] = 16'h8011;
        imem[17] = 16'hA140;
        release_reset();
        run_to_halt(0, 60, cyc);
        chk("jmp_cycles", cyc, 12);
        chk("jz_nt_pc", PC_Out, 7'h13);

        // JZ on R0 to 0x7F, then PC wraps to 0
        start_reset();
        imem[0]   = 16'hA07F;
        imem[127] = 16'h0000;
        release_reset();
        step(3);
        chk("jz_t_ireq", I_req, 1'b1);
        chk("jz_t_addr", I_addr, 7'h7F);
        step(3);
        chk("wrap_ireq", I_req, 1'b1);
        chk("wrap_addr", I_addr, 7'h00);

        // Reset during a MEM wait
        start_reset();
        imem[0] = 16'h8115;
        imem[1] = 16'h1540;
        dmem[64] = 16'hBEEF;
        dmem[65] = 16'hAAAA;
        d_wait = 20;
        release_reset();
        cyc = 0;
        while (!D_req && cyc < 20) begin
            step(1);
            cyc++;
        end
        chk("mw_enter_mem", D_req, 1'b1);
        step(2);
        #2;
        Reset = 1'b0;
        #1;
        chk("mw_dreq_drop", D_req, 1'b0);
        chk("mw_ireq_low", I_req, 1'b0);
        chk("mw_state", State, 4'd1);
        chk("mw_pc", PC_Out, 7'd0);
        clear_imem();
        imem[0] = 16'h1541;
        d_wait = 0;
        release_reset();
        #1;
        chk("mw_restart_addr", I_addr, 7'd0);
        run_to_halt(0, 40, cyc);
        chk("mw_no_store", dmem[64], 16'hBEEF);
        chk("mw_reg_cleared", dmem[65], 16'h0000);
        chk("mw_writes", wr_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
